// File: rtl/boot_loader_if.sv
// Byte-stream input, restart pulse, memory write port and status lines of the boot loader.
// The slave modport is the loader's view; the master modport is the stream source/memory side.
interface boot_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        restart;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_run;
    logic        error;

    modport slave (
        input  in_valid, in_data, restart,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_run, error
    );

    modport master (
        output in_valid, in_data, restart,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_run, error
    );
endinterface

// File: rtl/boot_loader.sv
// Framed byte-stream program loader: header, little-endian payload words written to memory,
// XOR checksum, then cpu_run release.
//
// state      | meaning
// -----------+----------------------------------------------------------
// HDR_ADDR   | collecting the 4 base-address bytes
// HDR_CNT    | collecting the 4 word-count bytes, range check on the last
// PAYLOAD    | assembling words, one memory write per 4 bytes
// CHECK      | comparing the checksum byte against the accumulator
// DONE       | image verified, cpu_run high, waiting for restart
// ERROR      | range or checksum failure, error high, waiting for restart
module boot_loader #(
    parameter int MEM_WORDS = 4096
) (
    input  logic          clk,
    input  logic          reset_n,
    boot_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_HDR_ADDR,
        S_HDR_CNT,
        S_PAYLOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] base_q, base_d;
    logic [23:0] cnt_q, cnt_d;
    logic [29:0] ptr_q, ptr_d;
    logic [31:0] remain_q, remain_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] asm_q, asm_d;
    logic [7:0]  csum_q, csum_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        in_ready;
    logic        accept;
    logic [31:0] cnt_full;
    logic [32:0] range_sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_HDR_ADDR;
            base_q      <= '0;
            cnt_q       <= '0;
            ptr_q       <= '0;
            remain_q    <= '0;
            byte_idx_q  <= '0;
            asm_q       <= '0;
            csum_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            remain_q    <= remain_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign in_ready  = (state_q == S_HDR_ADDR) || (state_q == S_HDR_CNT) ||
                       (state_q == S_PAYLOAD)  || (state_q == S_CHECK);
    assign accept    = bus.in_valid & in_ready;
    assign cnt_full  = {bus.in_data, cnt_q};
    // Word-granular end of image; 33 bits so a huge count cannot wrap past the check.
    assign range_sum = {3'b000, base_q} + {1'b0, cnt_full};

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        remain_d    = remain_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_HDR_ADDR: begin
                if (accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: base_d[5:0]   = bus.in_data[7:2];
                        2'd1: base_d[13:6]  = bus.in_data;
                        2'd2: base_d[21:14] = bus.in_data;
                        default: begin
                            base_d[29:22] = bus.in_data;
                            state_d       = S_HDR_CNT;
                        end
                    endcase
                end
            end
            S_HDR_CNT: begin
                if (accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: cnt_d[7:0]   = bus.in_data;
                        2'd1: cnt_d[15:8]  = bus.in_data;
                        2'd2: cnt_d[23:16] = bus.in_data;
                        default: begin
                            ptr_d    = base_q;
                            remain_d = cnt_full;
                            if (range_sum > 33'(MEM_WORDS))
                                state_d = S_ERROR;
                            else if (cnt_full == 32'd0)
                                state_d = S_CHECK;
                            else
                                state_d = S_PAYLOAD;
                        end
                    endcase
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    csum_d     = csum_q ^ bus.in_data;
                    case (byte_idx_q)
                        2'd0: asm_d[7:0]   = bus.in_data;
                        2'd1: asm_d[15:8]  = bus.in_data;
                        2'd2: asm_d[23:16] = bus.in_data;
                        default: begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = {ptr_q, 2'b00};
                            mem_wdata_d = {bus.in_data, asm_q};
                            ptr_d       = ptr_q + 30'd1;
                            remain_d    = remain_q - 32'd1;
                            if (remain_q == 32'd1)
                                state_d = S_CHECK;
                        end
                    endcase
                end
            end
            S_CHECK: begin
                if (accept)
                    state_d = (bus.in_data == csum_q) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (bus.restart) begin
                    csum_d     = '0;
                    byte_idx_d = '0;
                    state_d    = S_HDR_ADDR;
                end
            end
            default: state_d = S_HDR_ADDR;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_run   = (state_q == S_DONE);
    assign bus.error     = (state_q == S_ERROR);

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: framed images, checksum/range failures, stalls,
// mid-frame reset and restart.
module tb_boot_loader;

    logic clk;
    logic reset_n;
    boot_loader_if bus();

    boot_loader #(.MEM_WORDS(4096)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          wr_tot  = 0;
    logic [31:0] wa [64];
    logic [31:0] wd [64];
    logic [7:0]  csum_acc;
    int          w0;

    // Memory-side capture of every write strobe.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wa[wr_tot % 64] = bus.mem_addr;
            wd[wr_tot % 64] = bus.mem_wdata;
            wr_tot = wr_tot + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gap;
        gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w, input bit add_csum, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            if (add_csum) csum_acc = csum_acc ^ b;
            send_byte(b, maxgap);
        end
    endtask

    task automatic send_header(input logic [31:0] base, input logic [31:0] n, input int maxgap);
        csum_acc = 8'h00;
        send_word(base, 1'b0, maxgap);
        send_word(n, 1'b0, maxgap);
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [31:0] addr, input logic [31:0] data);
        chk({tag, "_addr"}, wa[idx % 64], addr);
        chk({tag, "_data"}, wd[idx % 64], data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.restart  = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_mem_we",   32'(bus.mem_we),   32'd0);
        chk("rst_addr",     bus.mem_addr,      32'h0);
        chk("rst_wdata",    bus.mem_wdata,     32'h0);
        chk("rst_cpu_run",  32'(bus.cpu_run),  32'd0);
        chk("rst_error",    32'(bus.error),    32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Two-word image
        w0 = wr_tot;
        send_header(32'h0, 32'd2, 0);
        send_word(32'h20080005, 1'b1, 0);
        send_word(32'h21090003, 1'b1, 0);
        chk("two_csum_model", 32'(csum_acc), 32'h06);
        chk("two_run_before", 32'(bus.cpu_run), 32'd0);
        send_byte(csum_acc, 0);
        chk("two_run_after", 32'(bus.cpu_run), 32'd1);
        chk("two_error", 32'(bus.error), 32'd0);
        chk("two_in_ready", 32'(bus.in_ready), 32'd0);
        chk("two_nwr", 32'(wr_tot - w0), 32'd2);
        check_write("two_w0", w0,     32'h0, 32'h20080005);
        check_write("two_w1", w0 + 1, 32'h4, 32'h21090003);
        repeat (3) tick();
        chk("two_run_hold", 32'(bus.cpu_run), 32'd1);
        chk("two_we_idle", 32'(bus.mem_we), 32'd0);

        // Bad checksum
        pulse_restart();
        chk("rs_run_drop", 32'(bus.cpu_run), 32'd0);
        chk("rs_in_ready", 32'(bus.in_ready), 32'd1);
        w0 = wr_tot;
        send_header(32'h0, 32'd2, 0);
        send_word(32'h20080005, 1'b1, 0);
        send_word(32'h21090003, 1'b1, 0);
        send_byte(csum_acc ^ 8'h01, 0);
        chk("bad_nwr", 32'(wr_tot - w0), 32'd2);
        chk("bad_error", 32'(bus.error), 32'd1);
        chk("bad_run", 32'(bus.cpu_run), 32'd0);
        chk("bad_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        repeat (2) tick();
        bus.in_valid = 1'b0;
        chk("bad_sticky", 32'(bus.error), 32'd1);

        // Range: last word fits
        pulse_restart();
        chk("rs_err_drop", 32'(bus.error), 32'd0);
        w0 = wr_tot;
        send_header(32'h00003FFC, 32'd1, 0);
        send_word(32'hDEADBEEF, 1'b1, 0);
        send_byte(csum_acc, 0);
        chk("rng_ok_run", 32'(bus.cpu_run), 32'd1);
        chk("rng_ok_nwr", 32'(wr_tot - w0), 32'd1);
        check_write("rng_ok", w0, 32'h3FFC, 32'hDEADBEEF);

        // Range: one word past the end
        pulse_restart();
        w0 = wr_tot;
        send_word(32'h00003FFC, 1'b0, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("rng_err_early", 32'(bus.error), 32'd0);
        send_byte(8'h00, 0);
        chk("rng_err", 32'(bus.error), 32'd1);
        chk("rng_err_ready", 32'(bus.in_ready), 32'd0);
        repeat (4) tick();
        chk("rng_err_nwr", 32'(wr_tot - w0), 32'd0);

        // Stalls and alignment
        pulse_restart();
        w0 = wr_tot;
        send_header(32'h00002003, 32'd1, 3);
        send_word(32'hA5C3_0F71, 1'b1, 3);
        send_byte(csum_acc, 3);
        chk("stall_run", 32'(bus.cpu_run), 32'd1);
        chk("stall_nwr", 32'(wr_tot - w0), 32'd1);
        check_write("stall", w0, 32'h2000, 32'hA5C30F71);

        // Empty image
        pulse_restart();
        w0 = wr_tot;
        send_header(32'h00000100, 32'd0, 0);
        chk("n0_run_before", 32'(bus.cpu_run), 32'd0);
        send_byte(8'h00, 0);
        chk("n0_run", 32'(bus.cpu_run), 32'd1);
        chk("n0_nwr", 32'(wr_tot - w0), 32'd0);

        // Reset while a write strobe is high
        pulse_restart();
        w0 = wr_tot;
        send_header(32'h00000100, 32'd2, 0);
        send_word(32'h11223344, 1'b1, 0);
        chk("arst_we_pre", 32'(bus.mem_we), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_we", 32'(bus.mem_we), 32'd0);
        chk("arst_addr", bus.mem_addr, 32'h0);
        chk("arst_wdata", bus.mem_wdata, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("arst_nwr", 32'(wr_tot - w0), 32'd0);

        // Reset after two payload bytes
        w0 = wr_tot;
        send_header(32'h00000000, 32'd1, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mrst_we", 32'(bus.mem_we), 32'd0);
        chk("mrst_run", 32'(bus.cpu_run), 32'd0);
        chk("mrst_error", 32'(bus.error), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        chk("mrst_nwr", 32'(wr_tot - w0), 32'd0);

        // Load, restart in DONE, load again
        w0 = wr_tot;
        send_header(32'h00000040, 32'd1, 0);
        send_word(32'hCAFEF00D, 1'b1, 0);
        send_byte(csum_acc, 0);
        chk("ld1_run", 32'(bus.cpu_run), 32'd1);
        check_write("ld1", w0, 32'h40, 32'hCAFEF00D);
        pulse_restart();
        chk("ld_restart_run", 32'(bus.cpu_run), 32'd0);
        send_header(32'h00000080, 32'd1, 0);
        send_word(32'h0BADC0DE, 1'b1, 0);
        chk("ld2_run_before", 32'(bus.cpu_run), 32'd0);
        send_byte(csum_acc, 0);
        chk("ld2_run", 32'(bus.cpu_run), 32'd1);
        chk("ld_nwr", 32'(wr_tot - w0), 32'd2);
        check_write("ld2", w0 + 1, 32'h80, 32'h0BADC0DE);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-stream program loader that fills the CPU's unified instruction/data memory before execution starts. It receives a framed image over a valid/ready byte interface, assembles little-endian 32-bit words and issues single-cycle writes to the memory write port. After a checksum check it asserts `cpu_run`, which releases the CPU.

## Interface
Parameters:
- `MEM_WORDS`, 4096 — memory depth in 32-bit words (byte range 0x0000–0x3FFF).

Ports:
- `clk`  in  1  — single clock; all logic is on the rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — byte available on `in_data`.
- `in_data`  in  8  — stream byte.
- `in_ready`  out  1  — loader accepts the byte; a transfer occurs when `in_valid & in_ready` at a rising edge.
- `restart`  in  1  — single-cycle pulse that returns the loader from DONE or ERROR to HDR_ADDR.
- `mem_we`  out  1  — memory write strobe, one cycle per word.
- `mem_addr`  out  32  — byte address, always word-aligned.
- `mem_wdata`  out  32  — write data.
- `cpu_run`  out  1  — high once the image has loaded and verified.
- `error`  out  1  — sticky load failure.

## Operation
Frame layout (every field little-endian):
- 4 bytes: base byte address. Bits [1:0] are forced to 0.
- 4 bytes: word count N.
- 4·N payload bytes.
- 1 checksum byte, equal to the XOR of all payload bytes. For N=0 the checksum is 0x00.

States:
- **HDR_ADDR**
  - `in_ready`=1.
  - Collects 4 bytes into the base register; on the 4th byte, goes to HDR_CNT.
- **HDR_CNT**
  - `in_ready`=1.
  - Collects 4 bytes into N.
  - On the 4th byte, range check: compute (base>>2)+N in 33-bit arithmetic. If the result is > `MEM_WORDS`, go to ERROR. Otherwise:
    - if N=0, go to CHECK;
    - else go to PAYLOAD.
  - The write pointer loads (base & ~3).
- **PAYLOAD**
  - `in_ready`=1.
  - A 2-bit byte index selects the lane; the byte goes into lane [8i+7:8i] of the assembly register.
  - Each byte is XORed into the checksum accumulator.
  - On lane 3: register the write (see Timing), then the pointer +4 and remaining −1. On the last word, go to CHECK.
- **CHECK**
  - `in_ready`=1.
  - One byte. If it equals the accumulator, go to DONE; else go to ERROR.
- **DONE**
  - `in_ready`=0, `cpu_run`=1.
- **ERROR**
  - `in_ready`=0, `error`=1, `cpu_run`=0.
- **restart**
  - Honoured only in DONE/ERROR; ignored in all other states.
  - Clears `cpu_run`, `error`, the checksum accumulator and the byte index, then goes to HDR_ADDR.

Rules:
- `in_ready` is a function of state only and never depends on `in_valid`.
- Bytes with `in_valid`=0 are not consumed and leave all state unchanged.
- A stalled stream may pause at any byte boundary indefinitely.

## Timing
- Reset values (asynchronous): state=HDR_ADDR, `in_ready`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_run`=0, `error`=0, and all internal counters and the accumulator 0.
- Write latency:
  - `mem_we`, `mem_addr` and `mem_wdata` are registered.
  - `mem_we` is high for exactly the one cycle after the edge that accepted byte lane 3.
  - `mem_addr`/`mem_wdata` hold their values until the next write.
- Back-to-back bytes at 1 per cycle give at most one `mem_we` every 4 cycles. No throughput stall.
- `cpu_run` rises on the cycle after the edge that accepted a matching checksum. It stays high until reset or restart.
- `error` rises on the cycle after the edge that accepted the failing byte (bad checksum, or the 4th count byte on a range violation).
- Reset asserted mid-frame aborts immediately:
  - `mem_we` drops asynchronously.
  - No partial word is written.
- The range check guarantees the pointer never exceeds byte address 4·`MEM_WORDS`−4. No wrap-around is possible.

## Test plan
- **Two-word image:** base 0x00000000, N=2, payload 0x20080005 then 0x21090003, checksum correct.
  - Two `mem_we` pulses: addr 0x0 / data 0x20080005, then addr 0x4 / data 0x21090003.
  - `cpu_run`=1 one cycle after the checksum byte.
- **Bad checksum:** same frame with the checksum byte XOR 0x01.
  - Both writes occur, then `error`=1, `cpu_run`=0, `in_ready`=0.
- **Range:** base 0x00003FFC with N=1 writes at 0x3FFC and then runs. Base 0x00003FFC with N=2 gives `error`=1 after the 4th count byte, with zero `mem_we` pulses.
- **Stalls and alignment:** base byte 0x2003 (aligned to 0x2000), N=1, with random `in_valid` gaps.
  - Single write at addr 0x2000 with correct data.
  - N=0 followed by checksum 0x00 reaches DONE with no writes.
- **Reset/restart:** deassert `reset_n` after 2 payload bytes.
  - All outputs return to reset values, with no write.
  - Then load a frame, pulse `restart` in DONE, and load a second frame: `cpu_run` drops, then rises again after the second checksum.
